// File: rtl/serial_add_seq_if.sv
// Operand/result handshakes and the full_adder link of the bit-serial sequencer.
// The master side is the environment: upstream, downstream and the adder together.
interface serial_add_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_carry_in;
    logic             fa_sum;
    logic             fa_carry_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output in_valid, op_a, op_b, cin, fa_sum, fa_carry_out, out_ready,
        input  in_ready, fa_a, fa_b, fa_carry_in, out_valid, result, cout
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, fa_sum, fa_carry_out, out_ready,
        output in_ready, fa_a, fa_b, fa_carry_in, out_valid, result, cout
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: feeds one bit pair per DRIVE/CAPTURE step into a
// 1-cycle-latency full_adder, LSB first, and assembles the parallel sum.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    serial_add_seq_if.slave  bus
);
    localparam int unsigned IDXW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [IDXW-1:0]  idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             cout_q,      cout_d;
    logic             fa_a_q,      fa_a_d;
    logic             fa_b_q,      fa_b_d;
    logic             fa_ci_q,     fa_ci_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;
    logic [WIDTH-1:0] a_nxt_c;
    logic [WIDTH-1:0] b_nxt_c;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            fa_a_q      <= 1'b0;
            fa_b_q      <= 1'b0;
            fa_ci_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            fa_a_q      <= fa_a_d;
            fa_b_q      <= fa_b_d;
            fa_ci_q     <= fa_ci_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next state; fa_* are loaded on the edge entering DRIVE so they are valid throughout it
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        cout_d      = cout_q;
        fa_a_d      = fa_a_q;
        fa_b_d      = fa_b_q;
        fa_ci_d     = fa_ci_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        a_nxt_c     = a_sh_q >> 1;
        b_nxt_c     = b_sh_q >> 1;

        case (state_q)
            ST_IDLE: begin
                fa_a_d  = 1'b0;
                fa_b_d  = 1'b0;
                fa_ci_d = 1'b0;
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d     = bus.op_a;
                    b_sh_d     = bus.op_b;
                    carry_d    = bus.cin;
                    idx_d      = '0;
                    result_d   = '0;
                    fa_a_d     = bus.op_a[0];
                    fa_b_d     = bus.op_b[0];
                    fa_ci_d    = bus.cin;
                    in_ready_d = 1'b0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (idx_q == IDXW'(i)) result_d[i] = bus.fa_sum;
                end
                carry_d = bus.fa_carry_out;
                if (idx_q == IDXW'(WIDTH - 1)) begin
                    cout_d      = bus.fa_carry_out;
                    fa_a_d      = 1'b0;
                    fa_b_d      = 1'b0;
                    fa_ci_d     = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    a_sh_d  = a_nxt_c;
                    b_sh_d  = b_nxt_c;
                    fa_a_d  = a_nxt_c[0];
                    fa_b_d  = b_nxt_c[0];
                    fa_ci_d = bus.fa_carry_out;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                fa_a_d  = 1'b0;
                fa_b_d  = 1'b0;
                fa_ci_d = 1'b0;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.fa_a        = fa_a_q;
    assign bus.fa_b        = fa_b_q;
    assign bus.fa_carry_in = fa_ci_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.cout        = cout_q;
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial operand sequencer that sits directly upstream of `full_adder`. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then presents one bit pair per step, LSB first, on the adder's `a`/`b`/`carry_in` inputs, and feeds each returned carry into the next step. It assembles the returned sum bits into a parallel result, which it offers downstream with its own valid/ready handshake.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range is 1 or more.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `in_valid` in 1: operand bundle valid.
- `in_ready` out 1: block can accept a bundle; equals (state == IDLE).
- `op_a` in WIDTH: first operand.
- `op_b` in WIDTH: second operand.
- `cin` in 1: carry into bit 0.
- `fa_a` out 1: drives `full_adder.a`; registered.
- `fa_b` out 1: drives `full_adder.b`; registered.
- `fa_carry_in` out 1: drives `full_adder.carry_in`; registered.
- `fa_sum` in 1: registered sum returned by `full_adder`.
- `fa_carry_out` in 1: registered carry returned by `full_adder`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `result` out WIDTH: assembled sum.
- `cout` out 1: carry out of bit WIDTH-1.

## Operation
- `full_adder` has a fixed latency of 1 cycle: inputs sampled at edge E produce `fa_sum`/`fa_carry_out` valid during the cycle after E.
- FSM states are IDLE, DRIVE, CAPTURE and DONE. Internal state is a shift register for A/B, a bit index of $clog2(WIDTH+1) bits, and a carry register.
- **IDLE:**
  - On `in_valid && in_ready`: latch `op_a`, `op_b` and `cin`; clear index and `result`; go to DRIVE.
  - Otherwise stay in IDLE.
- **DRIVE:** `fa_a`/`fa_b` carry operand bit[index]. `fa_carry_in` carries `cin` for index 0, else the latched carry. Go to CAPTURE.
- **CAPTURE:**
  - Write `fa_sum` into `result[index]`.
  - Latch `fa_carry_out` into the carry register.
  - If index == WIDTH-1: `cout` <= `fa_carry_out`, go to DONE.
  - Else: index++, go to DRIVE.
- **DONE:** `out_valid` = 1. `result` and `cout` are held stable. On `out_ready`, go to IDLE.
- Arithmetic: {`cout`, `result`} = `op_a` + `op_b` + `cin`, modulo 2^(WIDTH+1). No wider state.
- No overlap between operations: `in_ready` = 0 in DRIVE, CAPTURE and DONE. `in_valid` asserted in those states is ignored, not queued.
- `fa_*` outputs are driven to 0 in IDLE and DONE. In CAPTURE they hold their DRIVE values.

## Timing
- Reset values while `rstn` = 0 and immediately after release:
  - state = IDLE, so `in_ready` = 1.
  - `fa_a` = `fa_b` = `fa_carry_in` = 0.
  - `out_valid` = 0, `result` = 0, `cout` = 0; internal registers are 0.
- Reset assertion at any time aborts the current operation asynchronously. No partial result is ever presented.
- Cycle timeline, with the accepting edge at the end of cycle 0:
  - Cycle 1: DRIVE bit 0.
  - Cycle 2: CAPTURE bit 0.
  - Cycles 2i+1 / 2i+2: DRIVE / CAPTURE bit i.
  - Cycle 2·WIDTH+1: `out_valid` first high.
- Latency: 2·WIDTH+1 cycles from accept to `out_valid`. For WIDTH = 8, that is 17 cycles.
- Throughput: one operation per 2·WIDTH+2 cycles at best. The minimum is one DONE cycle with `out_ready` = 1, then one IDLE cycle.
- `out_ready` asserted in the first DONE cycle completes the transfer that cycle; `in_ready` is high on the next cycle.
- `out_ready` has no effect outside DONE.
- WIDTH = 1: a single DRIVE/CAPTURE pair; `out_valid` is high in cycle 3.

## Test plan
All scenarios use a real `full_adder` instance.
- **Basic add:** `op_a` = 0x5A, `op_b` = 0x3C, `cin` = 0, `out_ready` = 1 → `result` = 0x96, `cout` = 0. `out_valid` is high exactly 17 cycles after the accept edge.
- **Carry ripple:** 0xFF + 0x01, `cin` = 0 → `result` = 0x00, `cout` = 1.
- **All ones with carry-in:** 0xFF + 0xFF, `cin` = 1 → `result` = 0xFF, `cout` = 1. Check that `fa_carry_in` = 1 in every DRIVE cycle.
- **Backpressure:** 0x12 + 0x34 with `out_ready` held 0 for 5 DONE cycles → `result` stays 0x46 and `cout` stays 0, `out_valid` stays 1, and `in_ready` stays 0. A second `in_valid` pulse during this window is not accepted. After `out_ready` = 1, `in_ready` = 1 on the next cycle.
- **Reset mid-operation:** drop `rstn` during the DRIVE cycle of bit 3 → all outputs are 0 and `in_ready` = 1 immediately. After release, 0x01 + 0x01 gives `result` = 0x02, `cout` = 0.
- **Random regression:** 1000 random (`op_a`, `op_b`, `cin`) with random `out_ready` stalls → {`cout`, `result`} matches the reference sum every time, and the 17-cycle latency holds.
